// File: rtl/serial_link_obi_arbiter.sv
// Round-robin OBI arbiter sharing the serial-link OBI slave port between NumReq masters.
// Holds the address phase through link stalls and routes in-order responses via an ID FIFO.
module serial_link_obi_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   m_req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    m_addr_i,
    input  logic [NumReq-1:0]                   m_we_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]  m_be_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    m_wdata_i,
    output logic [NumReq-1:0]                   m_gnt_o,
    output logic [NumReq-1:0]                   m_rvalid_o,
    output logic [NumReq-1:0][DataWidth-1:0]    m_rdata_o,
    output logic                                sl_req_o,
    output logic [AddrWidth-1:0]                sl_addr_o,
    output logic                                sl_we_o,
    output logic [DataWidth/8-1:0]              sl_be_o,
    output logic [DataWidth-1:0]                sl_wdata_o,
    input  logic                                sl_gnt_i,
    input  logic                                sl_rvalid_i,
    input  logic [DataWidth-1:0]                sl_rdata_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                err_o
);

    localparam int unsigned IdW  = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [IdW-1:0]  lock_id_q, lock_id_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [IdW-1:0]  id_mem_q [MaxOutstanding];

    logic [IdW-1:0]  winner;
    logic [IdW-1:0]  head_id;
    logic            win_valid, not_full, handshake, resp_ok, spurious, drop_violation;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // While locked the stalled master keeps the port, whether or not it still requests.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        int tmp;
        tmp       = 0;
        winner    = '0;
        win_valid = 1'b0;
        if (lock_q) begin
            winner    = lock_id_q;
            win_valid = m_req_i[lock_id_q];
        end else begin
            for (int i = 0; i < int'(NumReq); i++) begin
                tmp = int'(rr_ptr_q) + i;
                if (tmp >= int'(NumReq)) tmp = tmp - int'(NumReq);
                if (!win_valid && m_req_i[IdW'(tmp)]) begin
                    win_valid = 1'b1;
                    winner    = IdW'(tmp);
                end
            end
        end
    end

    assign not_full       = (cnt_q < CntW'(MaxOutstanding));
    assign sl_req_o       = win_valid && not_full;
    assign handshake      = sl_req_o && sl_gnt_i;
    assign resp_ok        = sl_rvalid_i && (cnt_q != '0);
    assign spurious       = sl_rvalid_i && (cnt_q == '0);
    assign drop_violation = lock_q && !m_req_i[lock_id_q];
    assign head_id        = id_mem_q[rd_ptr_q];

    assign sl_addr_o  = win_valid ? m_addr_i[winner]  : '0;
    assign sl_we_o    = win_valid ? m_we_i[winner]    : 1'b0;
    assign sl_be_o    = win_valid ? m_be_i[winner]    : '0;
    assign sl_wdata_o = win_valid ? m_wdata_i[winner] : '0;

    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        if (handshake) m_gnt_o[winner] = 1'b1;
        if (resp_ok) begin
            m_rvalid_o[head_id] = 1'b1;
            m_rdata_o[head_id]  = sl_rdata_i;
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_d     = err_q | drop_violation | spurious;

        if (handshake) begin
            rr_ptr_d = (winner == IdW'(NumReq - 1)) ? '0 : winner + IdW'(1);
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (resp_ok) rd_ptr_d = ptr_inc(rd_ptr_q);

        if (handshake && !resp_ok)      cnt_d = cnt_q + CntW'(1);
        else if (!handshake && resp_ok) cnt_d = cnt_q - CntW'(1);

        if (handshake || drop_violation) begin
            lock_d = 1'b0;
        end else if (sl_req_o && !sl_gnt_i) begin
            lock_d    = 1'b1;
            lock_id_d = winner;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
        if (!rst_ni) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and counter alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (handshake) id_mem_q[wr_ptr_q] <= winner;
    end

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_serial_link_obi_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_serial_link_obi_arbiter;

    localparam int N    = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst_ni;
    logic [N-1:0]             m_req;
    logic [N-1:0][AW-1:0]     m_addr;
    logic [N-1:0]             m_we;
    logic [N-1:0][DW/8-1:0]   m_be;
    logic [N-1:0][DW-1:0]     m_wdata;
    logic [N-1:0]             m_gnt, m_rvalid;
    logic [N-1:0][DW-1:0]     m_rdata;
    logic                     sl_req, sl_we, sl_gnt, sl_rvalid, err;
    logic [AW-1:0]            sl_addr;
    logic [DW/8-1:0]          sl_be;
    logic [DW-1:0]            sl_wdata, sl_rdata;
    logic [$clog2(MAXO+1)-1:0] outstanding;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int mq[$];
    int m_rr = 0;
    bit m_lock = 1'b0;
    int m_lock_id = 0;
    bit m_err = 1'b0;
    // Per-cycle model decisions carried from evaluation to commit
    int md_win, md_cnt;
    bit md_wv, md_req, md_hs;
    logic [N-1:0] exp_gnt;

    serial_link_obi_arbiter #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
        .sl_req_o(sl_req), .sl_addr_o(sl_addr), .sl_we_o(sl_we), .sl_be_o(sl_be),
        .sl_wdata_o(sl_wdata), .sl_gnt_i(sl_gnt), .sl_rvalid_i(sl_rvalid), .sl_rdata_i(sl_rdata),
        .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        m_req = '0; m_addr = '0; m_we = '0; m_be = '0; m_wdata = '0;
        sl_gnt = 1'b0; sl_rvalid = 1'b0; sl_rdata = '0;
    endtask

    task automatic set_m(input int i, input logic [AW-1:0] a, input logic w,
                         input logic [DW/8-1:0] b, input logic [DW-1:0] d);
        m_addr[i] = a; m_we[i] = w; m_be[i] = b; m_wdata[i] = d;
    endtask

    // Evaluate the expected combinational outputs for the current inputs and compare.
    task automatic settle();
        logic [N-1:0]         e_rv;
        logic [N-1:0][DW-1:0] e_rd;
        #1;
        md_cnt = mq.size();
        md_win = 0;
        md_wv  = 1'b0;
        if (m_lock) begin
            md_win = m_lock_id;
            md_wv  = m_req[m_lock_id];
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (!md_wv && m_req[idx]) begin
                    md_wv  = 1'b1;
                    md_win = idx;
                end
            end
        end
        md_req  = md_wv && (md_cnt < MAXO);
        md_hs   = md_req && sl_gnt;
        exp_gnt = '0;
        if (md_hs) exp_gnt[md_win] = 1'b1;
        e_rv = '0;
        e_rd = '0;
        if (sl_rvalid && md_cnt > 0) begin
            e_rv[mq[0]] = 1'b1;
            e_rd[mq[0]] = sl_rdata;
        end
        if (chk_en) begin
            check("sl_req", 64'(sl_req), 64'(md_req));
            check("sl_addr", 64'(sl_addr), md_wv ? 64'(m_addr[md_win]) : 64'd0);
            check("sl_we", 64'(sl_we), md_wv ? 64'(m_we[md_win]) : 64'd0);
            check("sl_be", 64'(sl_be), md_wv ? 64'(m_be[md_win]) : 64'd0);
            check("sl_wdata", 64'(sl_wdata), md_wv ? 64'(m_wdata[md_win]) : 64'd0);
            check("m_gnt", 64'(m_gnt), 64'(exp_gnt));
            check("m_rvalid", 64'(m_rvalid), 64'(e_rv));
            check("m_rdata", 64'(m_rdata), 64'(e_rd));
            check("outstanding", 64'(outstanding), 64'(md_cnt));
            check("err", 64'(err), 64'(m_err));
        end
    endtask

    // Clock edge: update the model with the decisions made in settle().
    task automatic advance();
        @(posedge clk);
        if (!rst_ni) begin
            mq.delete(); m_rr = 0; m_lock = 1'b0; m_lock_id = 0; m_err = 1'b0;
        end else begin
            if (sl_rvalid) begin
                if (md_cnt > 0) void'(mq.pop_front());
                else m_err = 1'b1;
            end
            if (md_hs) begin
                mq.push_back(md_win);
                m_rr   = (md_win + 1) % N;
                m_lock = 1'b0;
            end else if (m_lock && !m_req[m_lock_id]) begin
                m_lock = 1'b0;
                m_err  = 1'b1;
            end else if (md_req && !sl_gnt) begin
                m_lock    = 1'b1;
                m_lock_id = md_win;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        settle();
        advance();
        rst_ni = 1'b1;
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
        @(negedge clk);
        settle(); advance();
        settle(); advance();
        rst_ni = 1'b1;
        chk_en = 1'b1;

        // Reset state
        settle();
        check("rst_sl_req", 64'(sl_req), 64'd0);
        check("rst_out", 64'(outstanding), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        advance();

        // Single write
        m_req = 2'b01; set_m(0, 32'h100, 1'b1, 4'hF, 32'hDEADBEEF); sl_gnt = 1'b1;
        settle();
        check("sw_gnt", 64'(m_gnt), 64'h1);
        check("sw_addr", 64'(sl_addr), 64'h100);
        check("sw_wdata", 64'(sl_wdata), 64'hDEADBEEF);
        advance();
        idle(); settle(); check("sw_out1", 64'(outstanding), 64'd1); advance();
        sl_rvalid = 1'b1; settle(); check("sw_rvalid", 64'(m_rvalid), 64'h1); advance();
        idle(); settle(); check("sw_out0", 64'(outstanding), 64'd0); advance();

        // Round-robin grants and in-order response routing
        do_reset();
        m_req = 2'b11; set_m(0, 32'h200, 1'b0, 4'hF, '0); set_m(1, 32'h300, 1'b0, 4'hF, '0);
        sl_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("rr_gnt", 64'(m_gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
            advance();
        end
        m_req = '0; sl_gnt = 1'b0; sl_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sl_rdata = 32'hA + 32'(k);
            settle();
            check("rr_rvalid", 64'(m_rvalid), (k % 2 == 0) ? 64'h1 : 64'h2);
            check("rr_rdata", 64'(m_rdata[k % 2]), 64'hA + 64'(k));
            advance();
        end
        sl_rvalid = 1'b0;

        // Stall lock: master 1 holds the port while master 0 joins
        m_req = 2'b10; set_m(1, 32'h1000, 1'b1, 4'h3, 32'h11111111); set_m(0, 32'h2000, 1'b0, 4'hF, '0);
        for (int k = 0; k < 3; k++) begin
            if (k >= 1) m_req = 2'b11;
            settle();
            check("stall_addr", 64'(sl_addr), 64'h1000);
            check("stall_gnt", 64'(m_gnt), 64'h0);
            advance();
        end
        sl_gnt = 1'b1; settle(); check("stall_gnt1", 64'(m_gnt), 64'h2); advance();
        m_req = 2'b01; settle(); check("stall_gnt0", 64'(m_gnt), 64'h1); advance();
        idle(); sl_rvalid = 1'b1;
        settle(); check("stall_rv1", 64'(m_rvalid), 64'h2); advance();
        settle(); check("stall_rv0", 64'(m_rvalid), 64'h1); advance();

        // Full: no forwarding at MaxOutstanding, no same-cycle bypass on rvalid
        idle(); m_req = 2'b01; set_m(0, 32'h40, 1'b1, 4'hF, 32'h55); sl_gnt = 1'b1;
        for (int k = 0; k < MAXO; k++) begin settle(); advance(); end
        settle();
        check("full_req", 64'(sl_req), 64'd0);
        check("full_out", 64'(outstanding), 64'(MAXO));
        advance();
        sl_rvalid = 1'b1; settle(); check("full_rv_req", 64'(sl_req), 64'd0); advance();
        sl_rvalid = 1'b0; settle();
        check("full_fwd", 64'(sl_req), 64'd1);
        check("full_out3", 64'(outstanding), 64'd3);
        advance();
        m_req = '0; sl_gnt = 1'b0; sl_rvalid = 1'b1;
        for (int k = 0; k < MAXO; k++) begin settle(); advance(); end

        // Spurious rvalid
        idle(); sl_rvalid = 1'b1;
        settle(); check("spur_rv", 64'(m_rvalid), 64'h0); advance();
        idle(); settle(); check("spur_err", 64'(err), 64'd1); check("spur_out", 64'(outstanding), 64'd0); advance();
        settle(); check("spur_sticky", 64'(err), 64'd1); advance();

        // Reset with transactions in flight
        do_reset();
        m_req = 2'b01; set_m(0, 32'h80, 1'b0, 4'hF, '0); sl_gnt = 1'b1;
        settle(); advance(); settle(); advance();
        idle(); rst_ni = 1'b0; settle(); advance(); rst_ni = 1'b1;
        settle(); check("rst_mid_out", 64'(outstanding), 64'd0); check("rst_mid_err", 64'(err), 64'd0); advance();
        sl_rvalid = 1'b1; settle(); check("rst_late_rv", 64'(m_rvalid), 64'h0); advance();
        idle(); settle(); check("rst_late_err", 64'(err), 64'd1); advance();

        // Locked master drops its request
        do_reset();
        m_req = 2'b01; set_m(0, 32'h500, 1'b1, 4'hF, 32'h77);
        settle(); check("drop_req1", 64'(sl_req), 64'd1); advance();
        m_req = 2'b00; settle(); check("drop_req0", 64'(sl_req), 64'd0); advance();
        settle(); check("drop_err", 64'(err), 64'd1); check("drop_req_nx", 64'(sl_req), 64'd0); advance();
        m_req = 2'b11; set_m(1, 32'h600, 1'b0, 4'hF, '0); sl_gnt = 1'b1;
        settle(); check("drop_resume", 64'(m_gnt), 64'h1); advance();
        idle(); sl_rvalid = 1'b1; settle(); advance();

        // Random traffic: masters hold requests until granted
        do_reset();
        exp_gnt = '0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(m_req[i] && !exp_gnt[i])) begin
                    m_req[i] = 1'($urandom_range(0, 1));
                    set_m(i, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
                end
            end
            sl_gnt    = ($urandom_range(0, 3) != 0);
            sl_rvalid = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
            sl_rdata  = $urandom;
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/serial_link_obi_arbiter.md
# serial_link_obi_arbiter

Round-robin OBI arbiter that shares the single OBI slave port of the serial-link wrapper (AXI-Lite bridge in front of `serial_link`) between `NumReq` masters, e.g. CPU and DMA. It sits between the system bus and the wrapper's `obi_req_i`/`obi_rsp_i`. It holds the address phase stable while the link stalls, and tracks up to `MaxOutstanding` in-flight transactions so in-order responses return to the correct master. It also exposes occupancy and protocol-error status.

## Interface
- `NumReq`, default 2: number of requesting masters, ≥2.
- `AddrWidth`, default 32: OBI address width.
- `DataWidth`, default 32: OBI data width; byte-enable width is `DataWidth/8`.
- `MaxOutstanding`, default 4: maximum number of accepted transactions without a response, ≥1.
- `clk_i` input, 1: single clock.
- `rst_ni` input, 1: reset; synchronous, active-low.
- `m_req_i` input, [NumReq]: per-master request.
- `m_addr_i` input, [NumReq][AddrWidth]: per-master address.
- `m_we_i` input, [NumReq]: per-master write enable.
- `m_be_i` input, [NumReq][DataWidth/8]: per-master byte enables.
- `m_wdata_i` input, [NumReq][DataWidth]: per-master write data.
- `m_gnt_o` output, [NumReq]: per-master grant.
- `m_rvalid_o` output, [NumReq]: per-master response valid.
- `m_rdata_o` output, [NumReq][DataWidth]: per-master read data.
- `sl_req_o` output, 1: request to the serial-link OBI port.
- `sl_addr_o` output, AddrWidth: address to the link.
- `sl_we_o` output, 1: write enable to the link.
- `sl_be_o` output, DataWidth/8: byte enables to the link.
- `sl_wdata_o` output, DataWidth: write data to the link.
- `sl_gnt_i` input, 1: link grant.
- `sl_rvalid_i` input, 1: link response valid.
- `sl_rdata_i` input, DataWidth: link read data.
- `outstanding_o` output, $clog2(MaxOutstanding+1): number of in-flight transactions.
- `err_o` output, 1: sticky protocol-error flag.

## Operation
- **State**
  - `rr_ptr`: round-robin pointer, $clog2(NumReq) bits.
  - `lock_q`/`lock_id_q`: address-phase lock and the locked master's index.
  - ID FIFO: depth `MaxOutstanding`, entries of $clog2(NumReq) bits.
  - `cnt_q`: outstanding counter.
  - `err_q`: sticky error flag.
- **Arbitration** (when `lock_q`=0)
  - Winner = first master with `m_req_i` set, scanning `rr_ptr`, `rr_ptr+1`, … mod `NumReq`.
  - While `lock_q`=1, the winner is `lock_id_q` unconditionally.
- **Forwarding**
  - `sl_req_o` = winner valid AND `cnt_q` < `MaxOutstanding`.
  - `sl_addr/we/be/wdata` are muxed from the winner; they are 0 when there is no winner.
- **Lock**
  - Set when `sl_req_o`=1 and `sl_gnt_i`=0; `lock_id_q` = winner.
  - Cleared on handshake.
  - Masters obey OBI and hold `m_req_i` until granted; a locked master dropping `m_req_i` is a protocol violation. In that case `err_q` sets, the lock clears and `sl_req_o` drops.
- **Handshake** (`sl_req_o`·`sl_gnt_i`)
  - `m_gnt_o[winner]` = 1, combinationally; all other grants are 0.
  - The winner index is pushed into the ID FIFO.
  - `rr_ptr` = winner+1 mod `NumReq`.
- **Response** (`sl_rvalid_i`)
  - Pop the FIFO head H; drive `m_rvalid_o[H]`=1 and `m_rdata_o[H]`=`sl_rdata_i`.
  - Non-selected `m_rdata_o` lanes are 0.
- **Counter**
  - `cnt_q` +1 on handshake, −1 on response, unchanged when both happen in the same cycle.
  - `outstanding_o` = `cnt_q`.
- **Full**
  - At `cnt_q` = `MaxOutstanding`, `sl_req_o` is held 0 even if `sl_rvalid_i` is 1 that cycle (no same-cycle bypass).
  - The lock cannot be set while full.
- **Spurious rvalid** (`sl_rvalid_i` with `cnt_q`=0)
  - No `m_rvalid_o` is asserted, `cnt_q` stays 0, and `err_q` sets.
- **Error flag**
  - `err_q` clears only on reset.
  - `err_o` = `err_q`.
- **Reset mid-operation**
  - FIFO, counter, lock and pointer clear, and in-flight IDs are discarded.
  - Responses arriving after reset hit the spurious-rvalid rule.

## Timing
- Reset values:
  - `rr_ptr`=0, `cnt_q`=0, FIFO empty, `lock_q`=0, `err_o`=0.
  - With all `m_req_i`=0: `sl_req_o`=0, all `m_gnt_o`=0, all `m_rvalid_o`=0, all `m_rdata_o`=0, `outstanding_o`=0.
- Request path: `m_req_i`→`sl_req_o` is 0-cycle combinational.
- Grant and response paths: `sl_gnt_i`→`m_gnt_o` and `sl_rvalid_i`→`m_rvalid_o` are also 0-cycle combinational; the arbiter adds no latency.
- Registered state (`rr_ptr`, lock, FIFO, `cnt_q`, `err_q`) updates on the rising edge following the event.
- A response can be routed no earlier than the cycle after its handshake, because the FIFO push is registered.
- Back-to-back handshakes: one per cycle while not full.

## Test plan
- **Single write:** master 0 writes addr 0x100, data 0xDEADBEEF; link grants the same cycle and responds 2 cycles later → `m_gnt_o`=01 in cycle 0, `outstanding_o`=1, `m_rvalid_o`=01 in cycle 2, then `outstanding_o`=0.
- **Round-robin:** both masters request continuously with `sl_gnt_i`=1 → grant order 0,1,0,1; responses with rdata 0xA,0xB,0xC,0xD route to masters 0,1,0,1 respectively.
- **Stall lock:** master 1 requests alone, `sl_gnt_i`=0 for 3 cycles, master 0 raises its request in cycle 1 → `sl_addr_o` stays at master 1's address until the grant in cycle 3; master 0 is granted next.
- **Full:** `MaxOutstanding`=4, 4 handshakes with no response → `sl_req_o`=0 with a request pending. An rvalid while full still keeps `sl_req_o`=0 that cycle; the request is forwarded the next cycle with `outstanding_o`=3.
- **Spurious/reset:** rvalid while `outstanding_o`=0 → no `m_rvalid_o`, `err_o`=1 sticky. Separately, `rst_ni`=0 with 2 in flight → `outstanding_o`=0 next cycle and a late rvalid sets `err_o`.
- **Drop violation:** a locked master deasserts `m_req_i` before grant → `err_o`=1, `sl_req_o`=0 next cycle, and arbitration resumes from `rr_ptr`.
